// File: rtl/shift_seq_counter_pkg.sv
// Shared encodings and sizing helper for the Johnson/ring shift sequence counter.
package shift_seq_counter_pkg;

  typedef enum logic {
    MODE_JOHNSON = 1'b0,
    MODE_RING    = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_DOWN = 1'b0,  // shift toward bit 0
    DIR_UP   = 1'b1   // shift toward bit N-1
  } dir_e;

  // Width of the phase index for an N-bit register (2N Johnson states).
  function automatic int unsigned phase_w(input int unsigned n);
    return $clog2(2 * n);
  endfunction

endpackage

// File: rtl/shift_seq_counter_decode.sv
// Combinational decode of the counter register into sequence phase and a legality flag.
module shift_seq_decode
  import shift_seq_counter_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = phase_w(N)
) (
  input  logic [N-1:0]  q,
  input  logic          mode,
  output logic [PW-1:0] phase,
  output logic          illegal
);

  localparam logic [N-1:0] ONES = '1;

  logic          j_legal;
  logic [PW-1:0] j_phase;
  logic          r_legal;
  logic [PW-1:0] r_phase;
  int unsigned   r_cnt;
  int unsigned   r_idx;

  // Johnson: k ones packed at the MSB end are phases 0..N, k ones at the LSB end are 2N-k.
  always_comb begin
    j_legal = 1'b0;
    j_phase = '0;
    for (int unsigned k = 0; k <= N; k++) begin
      if (q == ~(ONES >> k)) begin
        j_legal = 1'b1;
        j_phase = PW'(k);
      end
    end
    for (int unsigned k = 1; k < N; k++) begin
      if (q == ~(ONES << k)) begin
        j_legal = 1'b1;
        j_phase = PW'(2 * N - k);
      end
    end
  end

  // Ring: exactly one set bit; phase advances as the bit moves toward bit 0.
  always_comb begin
    r_cnt = 0;
    r_idx = 0;
    for (int unsigned i = 0; i < N; i++) begin
      if (q[i]) begin
        r_cnt = r_cnt + 1;
        r_idx = i;
      end
    end
    r_legal = (r_cnt == 1);
    r_phase = (r_idx == 0) ? '0 : PW'(N - r_idx);
  end

  always_comb begin
    illegal = (mode == MODE_RING) ? ~r_legal : ~j_legal;
    phase   = '0;
    if (!illegal) phase = (mode == MODE_RING) ? r_phase : j_phase;
  end

endmodule

// File: rtl/shift_seq_counter.sv
// Johnson / one-hot ring shift counter with parallel load, direction control,
// optional self-correction of illegal states and a registered wrap pulse.
module shift_seq_counter
  import shift_seq_counter_pkg::*;
#(
  parameter int unsigned N            = 4,
  parameter bit          SELF_CORRECT = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   mode,
  input  logic                   dir,
  input  logic                   load,
  input  logic [N-1:0]           load_val,
  output logic [N-1:0]           q,
  output logic [phase_w(N)-1:0]  phase,
  output logic                   tc,
  output logic                   illegal
);

  localparam int unsigned PW = phase_w(N);

  logic [N-1:0]  q_shift;
  logic [N-1:0]  q_nxt;
  logic          tc_nxt;
  logic [PW-1:0] last_ph;
  logic          wrap;

  shift_seq_decode #(
    .N  (N),
    .PW (PW)
  ) u_decode (
    .q       (q),
    .mode    (mode),
    .phase   (phase),
    .illegal (illegal)
  );

  // One shift step; Johnson inverts the bit that wraps around, ring does not.
  always_comb begin
    q_shift = q;
    unique case ({mode, dir})
      {MODE_JOHNSON, DIR_DOWN}: q_shift = {~q[0], q[N-1:1]};
      {MODE_JOHNSON, DIR_UP}:   q_shift = {q[N-2:0], ~q[N-1]};
      {MODE_RING, DIR_DOWN}:    q_shift = {q[0], q[N-1:1]};
      {MODE_RING, DIR_UP}:      q_shift = {q[N-2:0], q[N-1]};
      default:                  q_shift = q;
    endcase
  end

  always_comb begin
    last_ph = (mode == MODE_RING) ? PW'(N - 1) : PW'(2 * N - 1);
    wrap    = (dir == DIR_UP) ? (phase == '0) : (phase == last_ph);
  end

  // Next state: load beats enable; illegal states are repaired instead of shifted when enabled.
  always_comb begin
    q_nxt  = q;
    tc_nxt = 1'b0;
    if (load) begin
      q_nxt = load_val;
    end else if (en) begin
      if (illegal && SELF_CORRECT) begin
        q_nxt = (mode == MODE_RING) ? N'(1) : '0;
      end else begin
        q_nxt  = q_shift;
        tc_nxt = ~illegal & wrap;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q  <= '0;
      tc <= 1'b0;
    end else begin
      q  <= q_nxt;
      tc <= tc_nxt;
    end
  end

endmodule

// File: tb/tb_shift_seq_counter.sv
// Directed, table-driven bench for shift_seq_counter (N=4), plus reset and no-repair sequences.
module tb_shift_seq_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, mode, dir, load;
  logic [3:0] load_val;

  logic [3:0] q, q_nc;
  logic [2:0] phase, phase_nc;
  logic       tc, tc_nc, illegal, illegal_nc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_seq_counter #(.N(4), .SELF_CORRECT(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
    .load_val(load_val), .q(q), .phase(phase), .tc(tc), .illegal(illegal)
  );

  shift_seq_counter #(.N(4), .SELF_CORRECT(1'b0)) dut_nc (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
    .load_val(load_val), .q(q_nc), .phase(phase_nc), .tc(tc_nc), .illegal(illegal_nc)
  );

  typedef struct {
    logic       en, mode, dir, load;
    logic [3:0] lv;
    logic [3:0] eq;
    logic [2:0] eph;
    logic       etc, eill;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic e, m, d, l, input logic [3:0] lv, eq,
                     input logic [2:0] eph, input logic etc, eill);
    vec_t v;
    v.en = e; v.mode = m; v.dir = d; v.load = l; v.lv = lv;
    v.eq = eq; v.eph = eph; v.etc = etc; v.eill = eill;
    vecs.push_back(v);
  endtask

  // Drive inputs away from the edge, clock once, sample just after the edge.
  task automatic step(input logic e, m, d, l, input logic [3:0] lv);
    @(negedge clk);
    en = e; mode = m; dir = d; load = l; load_val = lv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = 4'h0;
    rst = 1'b0;
    #12;
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_tc", 32'(tc), 32'h0);
    chk("rst_phase", 32'(phase), 32'h0);
    chk("rst_illegal_j", 32'(illegal), 32'h0);
    mode = 1'b1;
    #1;
    chk("rst_illegal_r", 32'(illegal), 32'h1);
    mode = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    //   en  mode dir load lv      q        ph    tc   ill
    // Johnson down count through one full wrap
    add(1, 0, 0, 0, 4'h0, 4'b1000, 3'd1, 0, 0);
    add(1, 0, 0, 0, 4'h0, 4'b1100, 3'd2, 0, 0);
    add(1, 0, 0, 0, 4'h0, 4'b1110, 3'd3, 0, 0);
    add(1, 0, 0, 0, 4'h0, 4'b1111, 3'd4, 0, 0);
    add(1, 0, 0, 0, 4'h0, 4'b0111, 3'd5, 0, 0);
    add(1, 0, 0, 0, 4'h0, 4'b0011, 3'd6, 0, 0);
    add(1, 0, 0, 0, 4'h0, 4'b0001, 3'd7, 0, 0);
    add(1, 0, 0, 0, 4'h0, 4'b0000, 3'd0, 1, 0);
    add(0, 0, 0, 0, 4'h0, 4'b0000, 3'd0, 0, 0);
    // Johnson up: 0 -> last wraps immediately
    add(1, 0, 1, 0, 4'h0, 4'b0001, 3'd7, 1, 0);
    add(1, 0, 1, 0, 4'h0, 4'b0011, 3'd6, 0, 0);
    add(1, 0, 1, 0, 4'h0, 4'b0111, 3'd5, 0, 0);
    add(1, 0, 1, 0, 4'h0, 4'b1111, 3'd4, 0, 0);
    add(1, 0, 1, 0, 4'h0, 4'b1110, 3'd3, 0, 0);
    add(1, 0, 1, 0, 4'h0, 4'b1100, 3'd2, 0, 0);
    add(1, 0, 1, 0, 4'h0, 4'b1000, 3'd1, 0, 0);
    add(1, 0, 1, 0, 4'h0, 4'b0000, 3'd0, 0, 0);
    // Ring from all-zero: repair first, then rotate
    add(1, 1, 0, 0, 4'h0, 4'b0001, 3'd0, 0, 0);
    add(1, 1, 0, 0, 4'h0, 4'b1000, 3'd1, 0, 0);
    add(1, 1, 0, 0, 4'h0, 4'b0100, 3'd2, 0, 0);
    add(1, 1, 0, 0, 4'h0, 4'b0010, 3'd3, 0, 0);
    add(1, 1, 0, 0, 4'h0, 4'b0001, 3'd0, 1, 0);
    add(1, 1, 1, 0, 4'h0, 4'b0010, 3'd3, 1, 0);
    add(1, 1, 1, 0, 4'h0, 4'b0100, 3'd2, 0, 0);
    // Illegal load then repair
    add(0, 0, 0, 1, 4'b0101, 4'b0101, 3'd0, 0, 1);
    add(1, 0, 0, 0, 4'h0, 4'b0000, 3'd0, 0, 0);
    // Load beats enable, and clears a would-be wrap pulse
    add(1, 0, 0, 1, 4'b0011, 4'b0011, 3'd6, 0, 0);
    add(1, 0, 0, 0, 4'h0, 4'b0001, 3'd7, 0, 0);
    add(1, 0, 0, 1, 4'b1000, 4'b1000, 3'd1, 0, 0);
    // Mode switch while holding reinterprets q immediately
    add(0, 1, 0, 0, 4'h0, 4'b1000, 3'd1, 0, 0);
    add(1, 1, 0, 0, 4'h0, 4'b0100, 3'd2, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].mode, vecs[i].dir, vecs[i].load, vecs[i].lv);
      chk($sformatf("v%0d_q", i), 32'(q), 32'(vecs[i].eq));
      chk($sformatf("v%0d_phase", i), 32'(phase), 32'(vecs[i].eph));
      chk($sformatf("v%0d_tc", i), 32'(tc), 32'(vecs[i].etc));
      chk($sformatf("v%0d_illegal", i), 32'(illegal), 32'(vecs[i].eill));
    end

    // Asynchronous reset mid-count while tc is high
    step(0, 0, 0, 1, 4'h0);
    step(1, 0, 1, 0, 4'h0);
    chk("pre_arst_q", 32'(q), 32'h1);
    chk("pre_arst_tc", 32'(tc), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_q", 32'(q), 32'h0);
    chk("arst_tc", 32'(tc), 32'h0);
    chk("arst_phase", 32'(phase), 32'h0);
    chk("arst_illegal_j", 32'(illegal), 32'h0);
    mode = 1'b1;
    #1;
    chk("arst_illegal_r", 32'(illegal), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    en = 1'b1; mode = 1'b0; dir = 1'b0; load = 1'b0;
    @(posedge clk);
    #1;
    chk("post_arst_q", 32'(q), 32'b1000);
    chk("post_arst_tc", 32'(tc), 32'h0);

    // No-repair instance shifts illegal patterns as-is
    step(0, 1, 0, 1, 4'b0101);
    chk("nc_load_q", 32'(q_nc), 32'b0101);
    chk("nc_load_ill", 32'(illegal_nc), 32'h1);
    step(1, 1, 0, 0, 4'h0);
    chk("nc_ring_q", 32'(q_nc), 32'b1010);
    chk("nc_ring_ill", 32'(illegal_nc), 32'h1);
    chk("nc_ring_tc", 32'(tc_nc), 32'h0);
    chk("sc_ring_q", 32'(q), 32'b0001);
    step(0, 0, 0, 1, 4'b0101);
    step(1, 0, 0, 0, 4'h0);
    chk("nc_john_q", 32'(q_nc), 32'b0010);
    chk("nc_john_ill", 32'(illegal_nc), 32'h1);
    chk("sc_john_q", 32'(q), 32'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
